csr_axi_lite_slave: RTL and testbench
=====================================

# csr_axi_lite_slave

AXI4-Lite responder that terminates the host control channel, the register port driven by the GP master, and converts it into single-cycle register-bank accesses inside TOP_wrapper. Accepts one write and one read transaction at a time, issues a write strobe or read request to the CSR bank, and returns OKAY responses. Register index is the byte address divided by 4. Indices 0..127 are writable configuration registers. Indices 128..255 are read-only status registers; for example, index 142 is the elementwise performance counter.

## Interface
- LOG2_CSR_REG_NUM, 8: log2 of the register count; address width is LOG2_CSR_REG_NUM+2.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous reset, active-high.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_AWADDR  in  LOG2_CSR_REG_NUM+2  byte address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  ignored; writes are always full-word.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response.
- S_AXI_BRESP  out  2  constant 2'b00.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_ARADDR  in  LOG2_CSR_REG_NUM+2  byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read response.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  constant 2'b00.
- csr_wr_vld  out  1  one-cycle write strobe to the CSR bank.
- csr_wr_addr  out  LOG2_CSR_REG_NUM  register index.
- csr_wr_data  out  32  write data.
- csr_rd_en  out  1  one-cycle read request.
- csr_rd_addr  out  LOG2_CSR_REG_NUM  register index.
- csr_rd_data  in  32  valid the cycle after csr_rd_en.

## Operation
- **Register index:** ADDR[LOG2_CSR_REG_NUM+1:2]. Bits [1:0] are discarded.
- **Write FSM states:** W_COLLECT, W_EXEC, W_RESP.
  - W_COLLECT:
    - AWREADY = !aw_held; WREADY = !w_held.
    - AW and W are accepted in either order or in the same cycle, each latched independently.
    - When both are held, go to W_EXEC.
  - W_EXEC (exactly 1 cycle):
    - csr_wr_vld = 1, with the latched address and data.
    - Go to W_RESP.
  - W_RESP:
    - BVALID = 1, held until BREADY.
    - On the BVALID && BREADY handshake, clear aw_held and w_held and return to W_COLLECT.
    - AWREADY and WREADY are 0 in W_EXEC and W_RESP.
- **Read FSM states:** R_IDLE, R_REQ, R_WAIT, R_RESP.
  - R_IDLE: ARREADY = 1. On handshake, latch the index and go to R_REQ.
  - R_REQ: csr_rd_en = 1, then go to R_WAIT.
    - Exception: if the write FSM is in W_EXEC this cycle, stay in R_REQ with csr_rd_en = 0 (write-before-read ordering).
  - R_WAIT: register csr_rd_data into RDATA and go to R_RESP.
  - R_RESP: RVALID = 1 and RDATA stable until RREADY. On handshake, return to R_IDLE.
- Read and write FSMs are otherwise independent and may overlap.
- **Writes to indices >= 128** are still strobed to csr_wr_*. The bank ignores them. The response is OKAY.
- **Reads of any index** are forwarded to the bank. The response is OKAY.
- The block contains no register storage of its own.

## Timing
- **Reset values:** every output is 0 (AWREADY, WREADY, ARREADY, BVALID, RVALID, csr_wr_vld, csr_rd_en, addresses, data, RDATA). FSMs reset to W_COLLECT and R_IDLE; held flags are cleared.
- **READY after reset:** AWREADY, WREADY and ARREADY first go high the cycle after rst deasserts. They are registered and never depend combinationally on VALID.
- **Write latency:** last of the AW/W handshakes in cycle T → csr_wr_vld at T+1 → BVALID from T+2.
- **Read latency:** AR handshake in cycle T → csr_rd_en at T+1 → RDATA/RVALID from T+3.
  - Adds 1 cycle if the read collides with W_EXEC.
- **Backpressure:** a held-low BREADY or RREADY stalls only its own FSM. No new AW/W is accepted while BVALID is pending, and no new AR while RVALID is pending.
- **Reset mid-transaction:** rst drops any pending transaction and its response. The bank sees no strobe after the reset cycle.

## Test plan
- **Single write:** AW=0x010 and W=0xDEADBEEF in the same cycle, BREADY=1.
  - csr_wr_vld for exactly 1 cycle with index 4 and data 0xDEADBEEF.
  - BVALID 2 cycles after the handshake, BRESP=0.
- **Split write:** W=0x12345678 first, AW=0x020 five cycles later.
  - WREADY=0 after the W handshake.
  - Strobe at index 8 one cycle after the AW handshake.
- **Status read:** bank model returns 1234 for index 142; AR=0x238.
  - csr_rd_en at T+1 with index 142.
  - RDATA=1234 and RVALID at T+3, RRESP=0.
- **Write/read collision:** write 0x55 to index 3 completes (W_EXEC) in the same cycle the read FSM would issue its read of index 3.
  - csr_rd_en is delayed 1 cycle.
  - RDATA=0x55.
- **Backpressure:** RREADY=0 for 10 cycles.
  - RVALID and RDATA held stable.
  - ARREADY=0 throughout.
  - Next read is accepted only after the handshake.
- **Reset mid-read:** rst asserted in R_WAIT.
  - All outputs 0 the next cycle.
  - No RVALID is produced.
  - A fresh read afterwards completes normally.

Source files
------------

// File: rtl/csr_axi_lite_slave.sv
// AXI4-Lite responder that turns host control-channel transactions into
// single-cycle strobes and read requests on the CSR bank port.
module csr_axi_lite_slave #(
  parameter int LOG2_CSR_REG_NUM = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [LOG2_CSR_REG_NUM+1:0]   S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  output logic [1:0]                    S_AXI_BRESP,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  input  logic [LOG2_CSR_REG_NUM+1:0]   S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          csr_wr_vld,
  output logic [LOG2_CSR_REG_NUM-1:0]   csr_wr_addr,
  output logic [31:0]                   csr_wr_data,
  output logic                          csr_rd_en,
  output logic [LOG2_CSR_REG_NUM-1:0]   csr_rd_addr,
  input  logic [31:0]                   csr_rd_data
);

  localparam logic [1:0] W_COLLECT = 2'd0;
  localparam logic [1:0] W_EXEC    = 2'd1;
  localparam logic [1:0] W_RESP    = 2'd2;

  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_REQ     = 2'd1;
  localparam logic [1:0] R_WAIT    = 2'd2;
  localparam logic [1:0] R_RESP    = 2'd3;

  logic [1:0]                  wstate;
  logic [1:0]                  rstate;
  logic                        aw_held;
  logic                        w_held;
  logic                        awready;
  logic                        wready;
  logic                        arready;
  logic [LOG2_CSR_REG_NUM-1:0] wr_idx;
  logic [LOG2_CSR_REG_NUM-1:0] rd_idx;
  logic [31:0]                 wr_data;
  logic [31:0]                 rdata;
  logic                        aw_hs;
  logic                        w_hs;
  logic                        aw_got;
  logic                        w_got;
  logic                        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs  = S_AXI_AWVALID && awready;
  assign w_hs   = S_AXI_WVALID && wready;
  assign aw_got = aw_held || aw_hs;
  assign w_got  = w_held || w_hs;

  // READY flags are registered from the next-state so they never follow VALID
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate  <= W_COLLECT;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
    end else begin
      case (wstate)
        W_COLLECT: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            wr_idx  <= S_AXI_AWADDR[LOG2_CSR_REG_NUM+1:2];
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wr_data <= S_AXI_WDATA;
          end
          if (aw_got && w_got) begin
            wstate  <= W_EXEC;
            awready <= 1'b0;
            wready  <= 1'b0;
          end else begin
            awready <= !aw_got;
            wready  <= !w_got;
          end
        end
        W_EXEC: wstate <= W_RESP;
        W_RESP: begin
          if (S_AXI_BREADY) begin
            wstate  <= W_COLLECT;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: begin
          wstate  <= W_COLLECT;
          aw_held <= 1'b0;
          w_held  <= 1'b0;
          awready <= 1'b0;
          wready  <= 1'b0;
        end
      endcase
    end
  end

  // A read parked in R_REQ waits out W_EXEC so it observes the write's effect
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rd_idx  <= '0;
      rdata   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (S_AXI_ARVALID && arready) begin
            rd_idx  <= S_AXI_ARADDR[LOG2_CSR_REG_NUM+1:2];
            rstate  <= R_REQ;
            arready <= 1'b0;
          end else begin
            arready <= 1'b1;
          end
        end
        R_REQ: begin
          if (wstate != W_EXEC) rstate <= R_WAIT;
        end
        R_WAIT: begin
          rdata  <= csr_rd_data;
          rstate <= R_RESP;
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rstate  <= R_IDLE;
            arready <= 1'b1;
          end
        end
        default: begin
          rstate  <= R_IDLE;
          arready <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = (wstate == W_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = (rstate == R_RESP);
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;

  assign csr_wr_vld  = (wstate == W_EXEC);
  assign csr_wr_addr = wr_idx;
  assign csr_wr_data = wr_data;
  assign csr_rd_en   = (rstate == R_REQ) && (wstate != W_EXEC);
  assign csr_rd_addr = rd_idx;

endmodule

// File: tb/tb_csr_axi_lite_slave.sv
// Self-checking bench for csr_axi_lite_slave: directed cases plus randomized
// traffic against a transaction-level register model.
module tb_csr_axi_lite_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [9:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [9:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        csr_wr_vld;
  logic [7:0]  csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        csr_rd_en;
  logic [7:0]  csr_rd_addr;
  logic [31:0] csr_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] bank    [0:255];
  logic [31:0] exp_mem [0:127];

  csr_axi_lite_slave #(.LOG2_CSR_REG_NUM(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .csr_wr_vld    (csr_wr_vld),
    .csr_wr_addr   (csr_wr_addr),
    .csr_wr_data   (csr_wr_data),
    .csr_rd_en     (csr_rd_en),
    .csr_rd_addr   (csr_rd_addr),
    .csr_rd_data   (csr_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] status_val(input int idx);
    if (idx == 142) return 32'd1234;
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  // Register bank: config writable, status read-only, data one cycle after rd_en
  always @(posedge clk) begin
    if (csr_wr_vld && csr_wr_addr < 8'd128) bank[csr_wr_addr] <= csr_wr_data;
    if (csr_rd_en) csr_rd_data <= bank[csr_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID,
                           S_AXI_RVALID, csr_wr_vld, csr_rd_en}, 64'd0);
    check({tag, "_wr_bus"}, {csr_wr_addr, csr_wr_data}, 64'd0);
    check({tag, "_rd_bus"}, {csr_rd_addr, S_AXI_RDATA}, 64'd0);
  endtask

  task automatic axi_write(input logic [9:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, input int b_dly);
    int   cyc;
    bit   aw_done, w_done, aw_hs, w_hs;
    logic [7:0] idx;
    idx = addr[9:2];
    aw_done = 0;
    w_done  = 0;
    cyc     = 0;
    S_AXI_BREADY = 1'b0;
    while (!(aw_done && w_done) && cyc < 30) begin
      S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AXI_AWADDR  = addr;
      S_AXI_AWPROT  = 3'($urandom);
      S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = 4'($urandom);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      cyc++;
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      if (w_done && !aw_done) check("wready_after_w", S_AXI_WREADY, 0);
      if (aw_done && !w_done) check("awready_after_aw", S_AXI_AWREADY, 0);
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("wr_handshake_timeout", 64'(aw_done && w_done), 1);
    if (!(aw_done && w_done)) return;
    check("wr_vld_t1", csr_wr_vld, 1);
    check("wr_addr", csr_wr_addr, idx);
    check("wr_data", csr_wr_data, data);
    check("wr_ready_t1", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 0);
    tick();
    check("wr_vld_t2", csr_wr_vld, 0);
    check("bvalid_t2", S_AXI_BVALID, 1);
    check("bresp", S_AXI_BRESP, 0);
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("bvalid_hold", S_AXI_BVALID, 1);
      check("wr_ready_bp", {S_AXI_AWREADY, S_AXI_WREADY, csr_wr_vld}, 0);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("bvalid_done", S_AXI_BVALID, 0);
    check("wr_ready_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    if (idx < 8'd128) exp_mem[idx] = data;
  endtask

  task automatic axi_read(input logic [9:0] addr, input int r_dly);
    logic [7:0]  idx;
    logic [31:0] exp;
    int          cyc;
    idx = addr[9:2];
    exp = (idx < 8'd128) ? exp_mem[idx] : status_val(int'(idx));
    cyc = 0;
    S_AXI_RREADY = 1'b0;
    while (!S_AXI_ARREADY && cyc < 20) begin
      tick();
      cyc++;
    end
    check("arready_wait", S_AXI_ARREADY, 1);
    S_AXI_ARADDR  = addr;
    S_AXI_ARPROT  = 3'($urandom);
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    check("rd_en_t1", csr_rd_en, 1);
    check("rd_addr", csr_rd_addr, idx);
    check("arready_busy", S_AXI_ARREADY, 0);
    tick();
    check("rd_en_t2", {csr_rd_en, S_AXI_RVALID}, 0);
    tick();
    check("rvalid_t3", S_AXI_RVALID, 1);
    check("rdata", S_AXI_RDATA, exp);
    check("rresp", S_AXI_RRESP, 0);
    for (int i = 0; i < r_dly; i++) begin
      S_AXI_ARVALID = 1'b1;
      tick();
      check("rvalid_hold", S_AXI_RVALID, 1);
      check("rdata_hold", S_AXI_RDATA, exp);
      check("arready_bp", S_AXI_ARREADY, 0);
    end
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check("rvalid_done", S_AXI_RVALID, 0);
    check("arready_back", S_AXI_ARREADY, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) bank[i] = (i < 128) ? 32'd0 : status_val(i);
    for (int i = 0; i < 128; i++) exp_mem[i] = 32'd0;
    csr_rd_data   = '0;
    rst           = 1'b1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = '0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = '0;
    S_AXI_RREADY  = 1'b0;

    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    check("ready_before_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
    tick();
    check("ready_after_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // Single write, same-cycle AW/W
    axi_write(10'h010, 32'hDEADBEEF, 0, 0, 0);
    // Split write: W first, AW five cycles later
    axi_write(10'h020, 32'h12345678, 5, 0, 0);
    axi_read(10'h010, 0);
    axi_read(10'h020, 0);
    // Status read of the performance counter
    axi_read(10'h238, 0);
    // Write to a status index is strobed but leaves the register unchanged
    axi_write(10'h238, 32'hFFFF0000, 0, 2, 3);
    axi_read(10'h238, 0);

    // Write/read collision on index 3
    S_AXI_BREADY  = 1'b1;
    S_AXI_AWADDR  = 10'h00C;
    S_AXI_WDATA   = 32'h55;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARADDR  = 10'h00C;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    check("coll_wr_vld", csr_wr_vld, 1);
    check("coll_rd_en_blocked", csr_rd_en, 0);
    tick();
    check("coll_rd_en_late", csr_rd_en, 1);
    check("coll_rd_addr", csr_rd_addr, 3);
    check("coll_bvalid", S_AXI_BVALID, 1);
    tick();
    S_AXI_BREADY = 1'b0;
    check("coll_bdone", {S_AXI_BVALID, S_AXI_RVALID}, 0);
    tick();
    check("coll_rvalid", S_AXI_RVALID, 1);
    check("coll_rdata", S_AXI_RDATA, 32'h55);
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    exp_mem[3] = 32'h55;
    check("coll_rdone", S_AXI_RVALID, 0);

    // Read backpressure for 10 cycles
    axi_read(10'h00C, 10);
    axi_read(10'h010, 0);

    // Reset asserted while the read is in R_WAIT
    S_AXI_ARADDR  = 10'h010;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_outputs_zero("mid_read_reset");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_rvalid_after_reset", {S_AXI_RVALID, csr_wr_vld, csr_rd_en, S_AXI_BVALID}, 0);
    end
    axi_read(10'h010, 1);

    // Randomized traffic against the register model
    for (int n = 0; n < 60; n++) begin
      logic [7:0] idx;
      idx = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1))
        axi_write({idx, 2'($urandom)}, $urandom, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read({idx, 2'($urandom)}, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
